fp32_minmax_reduce_ctrl: RTL and testbench



---
 rtl/fp32_minmax_reduce_ctrl.sv | 153 +++++++++++++++
 tb/tb_fp32_minmax_reduce_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_minmax_reduce_ctrl.sv
`default_nettype none
// fp32_minmax_reduce_ctrl: folds an FP32 element stream into one max/min through an external pair comparator (rev 1.0).
// Optional FP32_NAN_EARLY_EXIT_EN: once the accumulator turns NaN, remaining elements are drained without compares.
module fp32_minmax_reduce_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_start,
    input  logic             s_is_max,
    input  logic [LEN_W-1:0] s_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             cmp_valid,
    output logic             cmp_is_max,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    input  logic             cmp_res_valid,
    input  logic [31:0]      cmp_res,
    output logic             o_busy,
    output logic             o_done,
    output logic [31:0]      o_res
);

    localparam logic [LEN_W-1:0] LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
`ifdef FP32_NAN_EARLY_EXIT_EN
    localparam logic [31:0]      NAN_VAL  = 32'hFFFF_FFFF;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FIRST = 3'd1,
        FETCH = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
`ifdef FP32_NAN_EARLY_EXIT_EN
        ,
        DRAIN = 3'd5
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      acc, acc_nxt;
    logic [LEN_W-1:0] rem, rem_nxt;
    logic             mode, mode_nxt;
    logic             issue;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        rem_nxt   = rem;
        mode_nxt  = mode;
        issue     = 1'b0;
        s_ready   = 1'b0;
        o_busy    = 1'b1;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (s_start) begin
                    mode_nxt = s_is_max;
                    rem_nxt  = s_len;
                    if (s_len == LEN_ZERO) begin
                        acc_nxt   = 32'h0;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FIRST;
                    end
                end
            end
            FIRST: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    acc_nxt   = s_data;
                    rem_nxt   = rem - LEN_ONE;
                    state_nxt = (rem == LEN_ONE) ? DONE : FETCH;
                end
            end
            FETCH: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    issue     = 1'b1;
                    rem_nxt   = rem - LEN_ONE;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cmp_res_valid) begin
                    acc_nxt = cmp_res;
                    if (rem == LEN_ZERO)
                        state_nxt = DONE;
`ifdef FP32_NAN_EARLY_EXIT_EN
                    else if (cmp_res == NAN_VAL)
                        state_nxt = DRAIN;
`endif
                    else
                        state_nxt = FETCH;
                end
            end
`ifdef FP32_NAN_EARLY_EXIT_EN
            DRAIN: begin
                // Accumulator is already the NaN pattern; elements are consumed and dropped.
                s_ready = 1'b1;
                if (s_valid) begin
                    rem_nxt = rem - LEN_ONE;
                    if (rem == LEN_ONE) state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc        <= 32'h0;
            rem        <= LEN_ZERO;
            mode       <= 1'b0;
            cmp_valid  <= 1'b0;
            cmp_is_max <= 1'b0;
            cmp_a      <= 32'h0;
            cmp_b      <= 32'h0;
            o_done     <= 1'b0;
            o_res      <= 32'h0;
        end else begin
            acc       <= acc_nxt;
            rem       <= rem_nxt;
            mode      <= mode_nxt;
            cmp_valid <= issue;
            if (issue) begin
                cmp_a      <= acc;
                cmp_b      <= s_data;
                cmp_is_max <= mode;
            end
            // Completion pulse and result are registered out of the DONE state.
            o_done <= (state == DONE);
            if (state == DONE) o_res <= acc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_minmax_reduce_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for fp32_minmax_reduce_ctrl with a 2-cycle comparator responder and a reduction model.
module tb_fp32_minmax_reduce_ctrl;
    localparam int          LEN_W   = 8;
    localparam logic [31:0] NAN_OUT = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             s_start = 1'b0;
    logic             s_is_max = 1'b0;
    logic [LEN_W-1:0] s_len = '0;
    logic             s_valid = 1'b0;
    logic [31:0]      s_data = 32'h0;
    logic             cmp_res_valid = 1'b0;
    logic [31:0]      cmp_res = 32'h0;
    logic             s_ready, cmp_valid, cmp_is_max, o_busy, o_done;
    logic [31:0]      cmp_a, cmp_b, o_res;

    always #5 clk = ~clk;

    fp32_minmax_reduce_ctrl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rstn(rstn), .s_start(s_start), .s_is_max(s_is_max), .s_len(s_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cmp_valid(cmp_valid), .cmp_is_max(cmp_is_max), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_res_valid(cmp_res_valid), .cmp_res(cmp_res),
        .o_busy(o_busy), .o_done(o_done), .o_res(o_res)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic [31:0] vec [8];
    logic [31:0] q_a [$];
    logic [31:0] q_b [$];
    logic        exp_mode = 1'b0;
    logic [31:0] exp_res = 32'h0;
    int          exp_ncmp = 0;
    int          exp_lat = 0;
    int          got_ncmp = 0;
    int          done_cyc = 0;
    logic [31:0] got_res = 32'h0;
    bit          done_seen = 1'b0;
    bit          sready_seen = 1'b0;
    bit          pending = 1'b0;
    logic [31:0] rsp = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction

    // Monotonic integer key: larger key means larger float value.
    function automatic logic [31:0] fkey(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    function automatic logic [31:0] fcmp(input logic [31:0] a, input logic [31:0] b, input logic mx);
        if (is_nan(a) || is_nan(b)) return NAN_OUT;
        if (mx) return (fkey(a) >= fkey(b)) ? a : b;
        return (fkey(a) <= fkey(b)) ? a : b;
    endfunction

    // Comparator: request seen in cycle N+1, result valid in cycle N+3.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_valid && rstn) begin
                rsp = fcmp(cmp_a, cmp_b, cmp_is_max);
                repeat (2) @(posedge clk);
                #1;
                cmp_res_valid = 1'b1;
                cmp_res       = rsp;
                @(posedge clk);
                #1;
                cmp_res_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            pending = 1'b0;
        end else begin
            if (s_ready) sready_seen = 1'b1;
            if (cmp_valid) begin
                got_ncmp++;
                pending = 1'b1;
                check("busy_on_cmp", {31'd0, o_busy}, 32'd1);
                if (q_a.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL cmp_extra: actual compare a=%h b=%h issued, required none", cmp_a, cmp_b);
                end else begin
                    check("cmp_a", cmp_a, q_a.pop_front());
                    check("cmp_b", cmp_b, q_b.pop_front());
                    check("cmp_is_max", {31'd0, cmp_is_max}, {31'd0, exp_mode});
                end
            end
            if (pending) check("s_ready_in_wait", {31'd0, s_ready}, 32'd0);
            if (cmp_res_valid) pending = 1'b0;
            if (o_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                got_res   = o_res;
                check("o_res", o_res, exp_res);
            end
        end
    end

    task automatic feed_one(input logic [31:0] d, input int idx);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        t = 0;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: actual s_ready low, required s_ready for element %0d", idx);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic start_vec(input bit mx, input int len);
        @(posedge clk);
        #1;
        s_start  = 1'b1;
        s_is_max = mx;
        s_len    = LEN_W'(len);
        t0       = cyc;
        @(posedge clk);
        #1;
        s_start  = 1'b0;
        s_is_max = ~mx;
        s_len    = 8'd7;
    endtask

    task automatic run_vec(input bit mx, input int len, input int gap, input bit poke,
                           input logic [31:0] lit_res, input int lit_ncmp);
        logic [31:0] acc;
        int nc;
        int t;
        q_a.delete();
        q_b.delete();
        exp_mode = mx;
        nc  = 0;
        acc = 32'h0;
        if (len > 0) begin
            acc = vec[0];
            for (int i = 1; i < len; i++) begin
                q_a.push_back(acc);
                q_b.push_back(vec[i]);
                acc = fcmp(acc, vec[i], mx);
                nc++;
`ifdef FP32_NAN_EARLY_EXIT_EN
                if (acc == NAN_OUT && i < len - 1) break;
`endif
            end
        end
        exp_res  = acc;
        exp_ncmp = nc;
        exp_lat  = (len == 0) ? 2 : 3 + 4 * nc + (len - 1 - nc);
        done_seen   = 1'b0;
        sready_seen = 1'b0;
        got_ncmp    = 0;

        start_vec(mx, len);
        for (int i = 0; i < len; i++) begin
            feed_one(vec[i], i);
            if (poke && i == 1) begin
                s_start  = 1'b1;
                s_len    = 8'd1;
                s_is_max = ~mx;
            end
            repeat (gap) begin
                @(posedge clk);
                #1;
                s_start = 1'b0;
            end
        end

        t = 0;
        while (!done_seen && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (!done_seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: actual no o_done, required o_done for len %0d", len);
        end else begin
            check("ncmp_model", got_ncmp, exp_ncmp);
            if (lit_ncmp >= 0) check("ncmp_literal", got_ncmp, lit_ncmp);
            check("o_res_literal", got_res, lit_res);
            if (gap == 0) check("latency", done_cyc - t0, exp_lat);
            check("compares_left", q_a.size(), 0);
            if (len == 0) check("s_ready_never", {31'd0, sready_seen}, 32'd0);
            check("idle_after_done", {29'd0, o_done, o_busy, s_ready}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {27'd0, o_done, o_busy, s_ready, cmp_valid, cmp_is_max}, 32'd0);
        check("reset_o_res", o_res, 32'h0);
        check("reset_cmp_a", cmp_a, 32'h0);
        check("reset_cmp_b", cmp_b, 32'h0);
        rstn = 1'b1;

        vec[0] = 32'h3F80_0000; vec[1] = 32'h4040_0000; vec[2] = 32'hC000_0000;
        run_vec(1'b1, 3, 0, 1'b0, 32'h4040_0000, 2);
        check("max3_latency_literal", done_cyc - t0, 32'd11);
        run_vec(1'b0, 3, 0, 1'b0, 32'hC000_0000, 2);

        vec[0] = 32'h7F7F_FFFF;
        run_vec(1'b1, 1, 0, 1'b0, 32'h7F7F_FFFF, 0);
        run_vec(1'b1, 0, 0, 1'b0, 32'h0000_0000, 0);
        check("len0_latency_literal", done_cyc - t0, 32'd2);

        vec[0] = 32'h3F80_0000; vec[1] = 32'h7FC0_0000; vec[2] = 32'h4000_0000; vec[3] = 32'h4100_0000;
`ifdef FP32_NAN_EARLY_EXIT_EN
        run_vec(1'b1, 4, 0, 1'b0, NAN_OUT, 1);
`else
        run_vec(1'b1, 4, 0, 1'b0, NAN_OUT, 3);
`endif

        vec[0] = 32'h40A0_0000; vec[1] = 32'hBF80_0000; vec[2] = 32'h3F00_0000; vec[3] = 32'hC120_0000;
        run_vec(1'b0, 4, 2, 1'b1, 32'hC120_0000, 3);

        // Abort inside WAIT; the comparator answer lands after reset and must be ignored.
        q_a.delete();
        q_b.delete();
        q_a.push_back(32'h3F80_0000);
        q_b.push_back(32'h4000_0000);
        exp_mode  = 1'b1;
        done_seen = 1'b0;
        start_vec(1'b1, 3);
        feed_one(32'h3F80_0000, 0);
        feed_one(32'h4000_0000, 1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", {31'd0, done_seen}, 32'd0);
        check("abort_ctl", {27'd0, o_done, o_busy, s_ready, cmp_valid, cmp_is_max}, 32'd0);
        check("abort_o_res", o_res, 32'h0);
        check("abort_cmp_a", cmp_a, 32'h0);
        check("abort_cmp_b", cmp_b, 32'h0);
        check("abort_compares_left", q_a.size(), 0);

        vec[0] = 32'h0000_0000; vec[1] = 32'h8000_0001;
        run_vec(1'b1, 2, 0, 1'b0, 32'h0000_0000, 1);
        check("len2_latency_literal", done_cyc - t0, 32'd7);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
